ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 158 +++++++++++++++
 tb/tb_ram_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single SPI RAM controller.
// Port A is the CPU, port B the loader/debug master.
module ram_arbiter #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [ADDR_BITS-1:0] a_addr,
    input  logic [DATA_BITS-1:0] a_wdata,
    output logic                 a_ack,
    output logic [DATA_BITS-1:0] a_rdata,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [ADDR_BITS-1:0] b_addr,
    input  logic [DATA_BITS-1:0] b_wdata,
    output logic                 b_ack,
    output logic [DATA_BITS-1:0] b_rdata,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    output logic                 mem_start_read,
    output logic                 mem_start_write,
    input  logic [DATA_BITS-1:0] mem_rdata,
    input  logic                 mem_busy,
    output logic                 grant_b
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 sel_b_q, sel_b_d;
    logic                 prio_b_q, prio_b_d;
    logic                 we_q, we_d;
    logic                 first_q, first_d;
    logic                 a_ack_q, a_ack_d;
    logic                 b_ack_q, b_ack_d;
    logic                 start_rd_q, start_rd_d;
    logic                 start_wr_q, start_wr_d;
    logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_BITS-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_BITS-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_BITS-1:0] b_rdata_q, b_rdata_d;
    logic                 pick_b;

    // Next-state and next-output logic; every output is a flop.
    always_comb begin
        state_d     = state_q;
        sel_b_d     = sel_b_q;
        prio_b_d    = prio_b_q;
        we_d        = we_q;
        first_d     = first_q;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        start_rd_d  = 1'b0;
        start_wr_d  = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        pick_b      = 1'b0;
        unique case (state_q)
            IDLE: begin
                mem_addr_d  = '0;
                mem_wdata_d = '0;
                if (!mem_busy && (a_req || b_req)) begin
                    // A lone requester wins outright; a tie goes to prio_b_q.
                    pick_b      = b_req && (!a_req || prio_b_q);
                    sel_b_d     = pick_b;
                    we_d        = pick_b ? b_we : a_we;
                    mem_addr_d  = pick_b ? b_addr : a_addr;
                    mem_wdata_d = pick_b ? b_wdata : a_wdata;
                    start_rd_d  = !we_d;
                    start_wr_d  = we_d;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                first_d = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                // The controller raises busy one cycle late, so the first
                // WAIT cycle cannot trust a low mem_busy.
                first_d = 1'b0;
                if (!first_q && !mem_busy) begin
                    state_d = DONE;
                    a_ack_d = !sel_b_q;
                    b_ack_d = sel_b_q;
                    if (!we_q) begin
                        if (sel_b_q) begin
                            b_rdata_d = mem_rdata;
                        end else begin
                            a_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            DONE: begin
                prio_b_d    = !sel_b_q;
                mem_addr_d  = '0;
                mem_wdata_d = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_b_q     <= 1'b0;
            prio_b_q    <= 1'b0;
            we_q        <= 1'b0;
            first_q     <= 1'b0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            start_rd_q  <= 1'b0;
            start_wr_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            sel_b_q     <= sel_b_d;
            prio_b_q    <= prio_b_d;
            we_q        <= we_d;
            first_q     <= first_d;
            a_ack_q     <= a_ack_d;
            b_ack_q     <= b_ack_d;
            start_rd_q  <= start_rd_d;
            start_wr_q  <= start_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
        end
    end

    assign a_ack           = a_ack_q;
    assign b_ack           = b_ack_q;
    assign a_rdata         = a_rdata_q;
    assign b_rdata         = b_rdata_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_start_read  = start_rd_q;
    assign mem_start_write = start_wr_q;
    assign grant_b         = sel_b_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed table, corner sequences and a
// randomized phase scored by a transaction-level model.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [15:0] a_addr = '0, a_wdata = '0;
    logic        a_ack;
    logic [15:0] a_rdata;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [15:0] b_addr = '0, b_wdata = '0;
    logic        b_ack;
    logic [15:0] b_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_start_read, mem_start_write, mem_busy;
    logic        grant_b;

    int n_chk = 0;
    int n_err = 0;

    ram_arbiter #(.ADDR_BITS(16), .DATA_BITS(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_start_read(mem_start_read), .mem_start_write(mem_start_write),
        .mem_rdata(mem_rdata), .mem_busy(mem_busy), .grant_b(grant_b)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // ---------------- SPI RAM controller model ----------------
    logic [15:0] cmem [0:65535];
    bit          cw   [0:65535];
    logic [15:0] rd_addr = '0;
    int          busy_cnt = 0;
    int          ctl_lat = 0;
    bit          rnd_lat = 1'b0;
    bit          hold_busy = 1'b0;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5555);
    endfunction

    function automatic logic [15:0] cval(input logic [15:0] a);
        return cw[a] ? cmem[a] : init_val(a);
    endfunction

    always @(posedge clk) begin
        if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        if (mem_start_read || mem_start_write) begin
            busy_cnt <= rnd_lat ? int'(mem_addr % 16'd5) : ctl_lat;
            rd_addr  <= mem_addr;
            if (mem_start_write) begin
                cmem[mem_addr] <= mem_wdata;
                cw[mem_addr]   <= 1'b1;
            end
        end
    end

    assign mem_busy  = (busy_cnt != 0) || hold_busy;
    assign mem_rdata = cval(rd_addr);

    // ---------------- event monitor ----------------
    int          n_rd = 0, n_wr = 0, n_aack = 0, n_back = 0;
    int          n_both = 0, n_ovl = 0;
    logic [15:0] st_addr = '0, st_wd = '0;

    always @(negedge clk) begin
        if (mem_start_read && mem_start_write) n_both++;
        if (a_ack && b_ack) n_ovl++;
        if (mem_start_read) n_rd++;
        if (mem_start_write) n_wr++;
        if (mem_start_read || mem_start_write) begin
            st_addr = mem_addr;
            st_wd   = mem_wdata;
        end
        if (a_ack) n_aack++;
        if (b_ack) n_back++;
    end

    // ---------------- transaction-level reference for random phase ----------------
    bit          rnd_on = 1'b0;
    int          cyc = 0;
    bit          pa_q = 1'b0, pb_q = 1'b0;
    bit          fav_b = 1'b0;
    int          exp_port = -1;
    bit          exp_we;
    logic [15:0] exp_addr, exp_wd;
    int          exp_cyc = 0;
    logic [15:0] ex_a = '0, ex_b = '0;
    bit          a_done = 1'b0, b_done = 1'b0;
    int          n_rnd_ack = 0;
    logic [15:0] sh_m [0:65535];
    bit          sh_w [0:65535];

    function automatic logic [15:0] sh_val(input logic [15:0] a);
        return sh_w[a] ? sh_m[a] : init_val(a);
    endfunction

    always @(negedge clk) begin
        int nb;
        bit gp;
        if (rnd_on) begin
            cyc++;
            if (mem_start_read || mem_start_write) begin
                if (!pa_q && !pb_q) begin
                    chk("rnd_start_without_req", 32'd1, 32'd0);
                end else begin
                    gp = (pa_q && pb_q) ? fav_b : pb_q;
                    chk("rnd_start_while_busy", exp_port, -1);
                    exp_port = gp ? 1 : 0;
                    exp_we   = gp ? b_we : a_we;
                    exp_addr = gp ? b_addr : a_addr;
                    exp_wd   = gp ? b_wdata : a_wdata;
                    chk("rnd_start_kind", {mem_start_write, mem_start_read},
                        exp_we ? 2'b10 : 2'b01);
                    chk("rnd_start_addr", mem_addr, exp_addr);
                    if (exp_we) chk("rnd_start_wdata", mem_wdata, exp_wd);
                    nb = int'(exp_addr % 16'd5);
                    exp_cyc = cyc + 2 + ((nb < 1) ? 1 : nb);
                end
            end
            if (a_ack || b_ack) begin
                chk("rnd_ack_port", {a_ack, b_ack},
                    (exp_port == 1) ? 2'b01 : ((exp_port == 0) ? 2'b10 : 2'b00));
                chk("rnd_ack_cycle", cyc, exp_cyc);
                if (exp_port >= 0) begin
                    if (exp_we) begin
                        sh_m[exp_addr] = exp_wd;
                        sh_w[exp_addr] = 1'b1;
                    end else if (exp_port == 1) begin
                        ex_b = sh_val(exp_addr);
                    end else begin
                        ex_a = sh_val(exp_addr);
                    end
                    fav_b = (exp_port == 0);
                    if (exp_port == 1) b_done = 1'b1;
                    else a_done = 1'b1;
                    n_rnd_ack++;
                    exp_port = -1;
                end
                chk("rnd_a_rdata", a_rdata, ex_a);
                chk("rnd_b_rdata", b_rdata, ex_b);
            end
            if (exp_port >= 0 && cyc > exp_cyc) begin
                chk("rnd_ack_timeout", 32'd0, 32'd1);
                exp_port = -1;
            end
        end
        pa_q = a_req;
        pb_q = b_req;
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    int          r_lat;
    bit          r_ok;
    logic [15:0] r_rd, r_oth_rd, r_done_addr;
    logic [31:0] r_idle_bus;
    bit          r_gb;
    int          r_nrd, r_nwr, r_oth_ack;

    task automatic do_txn(input bit pb, input bit we, input logic [15:0] ad,
                          input logic [15:0] wd, input int nb);
        int s_rd, s_wr, s_oth;
        ctl_lat = nb;
        s_rd = n_rd;
        s_wr = n_wr;
        s_oth = pb ? n_aack : n_back;
        @(posedge clk); #1;
        if (pb) begin
            b_we = we; b_addr = ad; b_wdata = wd; b_req = 1'b1;
        end else begin
            a_we = we; a_addr = ad; a_wdata = wd; a_req = 1'b1;
        end
        r_lat = 0;
        r_ok = 1'b0;
        while (!r_ok && r_lat < 60) begin
            @(posedge clk);
            r_lat++;
            @(negedge clk);
            if (pb ? b_ack : a_ack) r_ok = 1'b1;
        end
        r_done_addr = mem_addr;
        r_gb = grant_b;
        r_rd = pb ? b_rdata : a_rdata;
        r_oth_rd = pb ? a_rdata : b_rdata;
        @(posedge clk); #1;
        a_req = 1'b0;
        b_req = 1'b0;
        @(negedge clk);
        r_idle_bus = {mem_addr, mem_wdata};
        r_nrd = n_rd - s_rd;
        r_nwr = n_wr - s_wr;
        r_oth_ack = (pb ? n_aack : n_back) - s_oth;
    endtask

    typedef struct {
        bit          pb;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wd;
        int          nb;
        int          lat;
        logic [15:0] rd;
    } vec_t;

    vec_t        tv [7];
    logic [15:0] exp_a_rd, exp_b_rd;
    int          ord [$];
    int          ovl, sa, s_rd0, s_wr0;
    bit          seen, busy_prev, busy_at_start;
    bit          a_pend, b_pend;
    int          a_age, b_age;

    initial begin
        //        pb  we   addr      wdata    nb lat rdata-after
        tv[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 3, 6, 16'hBEEF};
        tv[1] = '{1'b1, 1'b1, 16'h1234, 16'h5A5A, 2, 5, 16'h0000};
        tv[2] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 0, 4, 16'h5A5A};
        tv[3] = '{1'b0, 1'b1, 16'h00FF, 16'h1111, 1, 4, 16'hBEEF};
        tv[4] = '{1'b0, 1'b0, 16'h00FF, 16'h0000, 5, 8, 16'h1111};
        tv[5] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 0, 4, 16'hAAAA};
        tv[6] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1, 4, 16'h5555};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_acks", {a_ack, b_ack}, 2'b00);
        chk("rst_starts", {mem_start_read, mem_start_write}, 2'b00);
        chk("rst_mem_bus", {mem_addr, mem_wdata}, 32'h0);
        chk("rst_rdata", {a_rdata, b_rdata}, 32'h0);
        chk("rst_grant_b", grant_b, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed single-port table
        exp_a_rd = '0;
        exp_b_rd = '0;
        for (int i = 0; i < 7; i++) begin
            do_txn(tv[i].pb, tv[i].we, tv[i].addr, tv[i].wd, tv[i].nb);
            chk($sformatf("v%0d_acked", i), r_ok, 1'b1);
            chk($sformatf("v%0d_latency", i), r_lat, tv[i].lat);
            chk($sformatf("v%0d_rdata", i), r_rd, tv[i].rd);
            chk($sformatf("v%0d_other_rdata", i), r_oth_rd,
                tv[i].pb ? exp_a_rd : exp_b_rd);
            chk($sformatf("v%0d_read_starts", i), r_nrd, tv[i].we ? 0 : 1);
            chk($sformatf("v%0d_write_starts", i), r_nwr, tv[i].we ? 1 : 0);
            chk($sformatf("v%0d_start_addr", i), st_addr, tv[i].addr);
            if (tv[i].we) chk($sformatf("v%0d_start_wdata", i), st_wd, tv[i].wd);
            chk($sformatf("v%0d_other_ack", i), r_oth_ack, 0);
            chk($sformatf("v%0d_done_addr", i), r_done_addr, tv[i].addr);
            chk($sformatf("v%0d_idle_bus", i), r_idle_bus, 32'h0);
            chk($sformatf("v%0d_grant_b", i), r_gb, tv[i].pb);
            if (tv[i].pb) exp_b_rd = tv[i].rd;
            else exp_a_rd = tv[i].rd;
        end

        // Request dropped (and inputs scrambled) after ISSUE
        ctl_lat = 2;
        @(posedge clk); #1;
        a_we = 1'b1; a_addr = 16'h0040; a_wdata = 16'h7777; a_req = 1'b1;
        sa = n_aack; s_rd0 = n_rd; s_wr0 = n_wr;
        repeat (2) @(posedge clk);
        #1;
        a_we = 1'b0; a_addr = 16'hDEAD; a_wdata = 16'h0000; a_req = 1'b0;
        repeat (20) @(negedge clk);
        chk("drop_ack_count", n_aack - sa, 1);
        chk("drop_write_starts", n_wr - s_wr0, 1);
        chk("drop_read_starts", n_rd - s_rd0, 0);
        chk("drop_start_addr", st_addr, 16'h0040);
        chk("drop_start_wdata", st_wd, 16'h7777);
        chk("drop_mem_written", cval(16'h0040), 16'h7777);
        chk("drop_idle_bus", {mem_addr, mem_wdata}, 32'h0);
        chk("drop_a_rdata", a_rdata, exp_a_rd);

        // A port-B read so grant_b and b_rdata are non-zero before reset
        do_txn(1'b1, 1'b0, 16'h0000, 16'h0000, 1);
        chk("pre_rst_b_latency", r_lat, 4);
        chk("pre_rst_b_rdata", r_rd, 16'h5555);
        chk("pre_rst_grant_b", r_gb, 1'b1);

        // Reset during WAIT with the controller busy
        ctl_lat = 10;
        @(posedge clk); #1;
        a_we = 1'b0; a_addr = 16'h0010; a_req = 1'b1;
        sa = n_aack;
        repeat (4) @(posedge clk);
        #1;
        hold_busy = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_acks", {a_ack, b_ack}, 2'b00);
        chk("mid_rst_starts", {mem_start_read, mem_start_write}, 2'b00);
        chk("mid_rst_mem_bus", {mem_addr, mem_wdata}, 32'h0);
        chk("mid_rst_rdata", {a_rdata, b_rdata}, 32'h0);
        chk("mid_rst_grant_b", grant_b, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        s_rd0 = n_rd;
        repeat (8) @(negedge clk);
        chk("post_rst_no_start", n_rd - s_rd0, 0);
        chk("post_rst_no_ack", n_aack - sa, 0);
        @(posedge clk); #1;
        hold_busy = 1'b0;
        seen = 1'b0;
        busy_prev = 1'b1;
        busy_at_start = 1'b1;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (mem_start_read) begin
                seen = 1'b1;
                busy_at_start = busy_prev;
            end
            busy_prev = mem_busy;
        end
        chk("post_rst_start_seen", seen, 1'b1);
        chk("post_rst_busy_before_start", busy_at_start, 1'b0);
        for (int c = 0; c < 40 && (n_aack - sa) == 0; c++) @(negedge clk);
        chk("post_rst_ack_count", n_aack - sa, 1);
        chk("post_rst_a_rdata", a_rdata, 16'hBEEF);
        @(posedge clk); #1;
        a_req = 1'b0;

        // Both ports hold read requests right after reset
        do_reset();
        ctl_lat = 1;
        a_we = 1'b0; a_addr = 16'h0010;
        b_we = 1'b0; b_addr = 16'h0000;
        a_req = 1'b1; b_req = 1'b1;
        ovl = 0;
        for (int c = 0; c < 60 && ord.size() < 4; c++) begin
            @(negedge clk);
            if (a_ack && b_ack) ovl++;
            else if (a_ack) ord.push_back(0);
            else if (b_ack) ord.push_back(1);
        end
        @(posedge clk); #1;
        a_req = 1'b0; b_req = 1'b0;
        chk("rr_ack_count", ord.size(), 4);
        for (int i = 0; i < ord.size(); i++) chk($sformatf("rr_order%0d", i), ord[i], i % 2);
        chk("rr_ack_overlap", ovl, 0);
        chk("rr_a_rdata", a_rdata, 16'hBEEF);
        chk("rr_b_rdata", b_rdata, 16'h5555);
        repeat (12) @(posedge clk);

        // Randomized traffic against the reference model
        do_reset();
        rnd_lat = 1'b1;
        fav_b = 1'b0;
        ex_a = '0;
        ex_b = '0;
        exp_port = -1;
        a_pend = 1'b0; b_pend = 1'b0;
        a_age = 0; b_age = 0;
        rnd_on = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (a_done) begin a_pend = 1'b0; a_done = 1'b0; end
            if (b_done) begin b_pend = 1'b0; b_done = 1'b0; end
            if (!a_pend && $urandom_range(0, 2) == 0) begin
                a_pend = 1'b1; a_age = 0;
                a_we = 1'($urandom_range(0, 1));
                a_addr = 16'h0100 + 16'($urandom_range(0, 15));
                a_wdata = 16'($urandom);
            end
            if (!b_pend && $urandom_range(0, 2) == 0) begin
                b_pend = 1'b1; b_age = 0;
                b_we = 1'($urandom_range(0, 1));
                b_addr = 16'h0100 + 16'($urandom_range(0, 15));
                b_wdata = 16'($urandom);
            end
            a_req = a_pend;
            b_req = b_pend;
            if (a_pend) a_age++;
            if (b_pend) b_age++;
            if (a_age == 60) chk("rnd_a_starved", a_age, 0);
            if (b_age == 60) chk("rnd_b_starved", b_age, 0);
        end
        a_req = 1'b0; b_req = 1'b0;
        repeat (30) @(posedge clk);
        rnd_on = 1'b0;
        chk("rnd_enough_acks", n_rnd_ack > 100, 1'b1);

        chk("never_both_starts", n_both, 0);
        chk("never_both_acks", n_ovl, 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
